// File: rtl/sb_cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package sb_cfg_pkg;

    localparam int N_TB     = 5;
    localparam int N_LR     = 4;
    localparam int SEL_W    = 6;
    localparam int N_ENT    = 2 * N_TB + 2 * N_LR;
    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {
        SIDE_NONE   = 3'd0,
        SIDE_TOP    = 3'd1,
        SIDE_RIGHT  = 3'd2,
        SIDE_BOTTOM = 3'd3,
        SIDE_LEFT   = 3'd4
    } side_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_PARITY = 2'd1,
        ERR_SIDE   = 2'd2,
        ERR_INDEX  = 2'd3
    } err_e;

    typedef enum logic [1:0] {HUNT, LOAD, DONE, ERR} state_e;

    // Physical edge that output slot k drives.
    function automatic side_e ent_side(input int k);
        if (k < N_TB)                 return SIDE_TOP;
        else if (k < 2 * N_TB)        return SIDE_BOTTOM;
        else if (k < 2 * N_TB + N_LR) return SIDE_LEFT;
        else                          return SIDE_RIGHT;
    endfunction

    // Number of selectable wires on a side; SIDE_NONE accepts any index.
    function automatic logic [3:0] ent_limit(input logic [2:0] side);
        case (side)
            SIDE_NONE:               return 4'd8;
            SIDE_TOP, SIDE_BOTTOM:   return 4'(N_TB);
            SIDE_RIGHT, SIDE_LEFT:   return 4'(N_LR);
            default:                 return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sb_cfg_entry_chk.sv
// Combinational legality check of one received entry and its even-parity bit.
module sb_cfg_entry_chk
    import sb_cfg_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             par,
    output logic             err_valid,
    output logic [1:0]       err_code
);

    always_comb begin
        err_valid = 1'b0;
        err_code  = ERR_NONE;
        if (^{sel, par}) begin
            err_valid = 1'b1;
            err_code  = ERR_PARITY;
        end else if (sel[2:0] > SIDE_LEFT) begin
            err_valid = 1'b1;
            err_code  = ERR_SIDE;
        end else if ({1'b0, sel[5:3]} >= ent_limit(sel[2:0])) begin
            err_valid = 1'b1;
            err_code  = ERR_INDEX;
        end
    end

endmodule

// File: rtl/sb_cfg_loader.sv
// Framed serial loader for the 18 route-select registers; commits a frame only if every entry is good.
module sb_cfg_loader
    import sb_cfg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_clr,
    input  logic                     bit_valid,
    input  logic                     bit_data,
    output logic                     bit_ready,
    output logic [N_ENT*SEL_W-1:0]   cfg_out,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [1:0]               err_code
);

    state_e                 state, state_nxt;
    logic [7:0]             hunt_sr;
    logic [4:0]             ent;
    logic [2:0]             bcnt;
    logic                   err_seen;
    logic [1:0]             err_first;
    logic [SEL_W-1:0]       shadow [N_ENT];
    logic [N_ENT*SEL_W-1:0] shadow_flat;
    logic [SEL_W-1:0]       cur_sel;
    logic                   xfer, hdr_hit, par_bit, last_ent;
    logic                   chk_valid;
    logic [1:0]             chk_code;

    assign bit_ready = (state == HUNT) || (state == LOAD);
    assign xfer      = bit_valid && bit_ready;
    assign hdr_hit   = ({hunt_sr[6:0], bit_data} == HDR);
    assign par_bit   = (bcnt == 3'd6);
    assign last_ent  = (ent == 5'(N_ENT - 1));
    assign cur_sel   = shadow[ent];

    always_comb begin
        shadow_flat = '0;
        for (int k = 0; k < N_ENT; k++) shadow_flat[k*SEL_W +: SEL_W] = shadow[k];
    end

    sb_cfg_entry_chk u_chk (
        .sel       (cur_sel),
        .par       (bit_data),
        .err_valid (chk_valid),
        .err_code  (chk_code)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            HUNT: if (xfer && hdr_hit) state_nxt = LOAD;
            LOAD: if (xfer && par_bit && last_ent) state_nxt = (err_seen || chk_valid) ? ERR : DONE;
            DONE: state_nxt = HUNT;
            ERR:  state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            hunt_sr   <= '0;
            ent       <= '0;
            bcnt      <= '0;
            err_seen  <= 1'b0;
            err_first <= ERR_NONE;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_code  <= ERR_NONE;
            cfg_out   <= '0;
        end else begin
            state    <= state_nxt;
            cfg_done <= (state_nxt == DONE);
            cfg_err  <= (state_nxt == ERR);
            if (state_nxt == ERR) err_code <= err_seen ? err_first : chk_code;
            // A clear always beats a same-cycle commit.
            if (cfg_clr)                cfg_out <= '0;
            else if (state_nxt == DONE) cfg_out <= shadow_flat;

            if (state == DONE || state == ERR) hunt_sr <= '0;
            else if (state == HUNT && xfer)    hunt_sr <= {hunt_sr[6:0], bit_data};

            if (state == HUNT && xfer && hdr_hit) begin
                ent      <= '0;
                bcnt     <= '0;
                err_seen <= 1'b0;
            end else if (state == LOAD && xfer) begin
                if (par_bit) begin
                    bcnt <= '0;
                    ent  <= ent + 5'd1;
                    if (chk_valid && !err_seen) begin
                        err_seen  <= 1'b1;
                        err_first <= chk_code;
                    end
                end else begin
                    bcnt <= bcnt + 3'd1;
                end
            end
        end
    end

    // Shadow entries fill MSB first; the parity bit leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ENT; k++) shadow[k] <= '0;
        end else if (state == LOAD && xfer && !par_bit) begin
            shadow[ent] <= {shadow[ent][SEL_W-2:0], bit_data};
        end
    end

endmodule
